// File: rtl/bshift_pipe8_if.sv
// bshift_pipe8_if: valid/ready operand and result channels of the pipelined barrel shifter
interface bshift_pipe8_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, busy
  );
  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/bshift_pipe8.sv
// bshift_pipe8: three-stage elastic barrel shifter, stage k shifts by 2**k when amt bit k is set
module bshift_pipe8 #(
  parameter int         DATA_W   = 8,
  parameter logic [7:0] RST_DATA = 8'h00
) (
  input logic          clk,
  input logic          rst,
  bshift_pipe8_if.slave b
);
  logic [2:0]        v, sv, rdy;
  logic [DATA_W-1:0] d [3];
  logic [DATA_W-1:0] sd [3];
  logic [2:0]        a [3];
  logic [2:0]        sa [3];
  logic [1:0]        m [3];
  logic [1:0]        sm [3];
  function automatic logic [7:0] sh(input logic [7:0] x, input logic [1:0] md, input logic [3:0] s);
    logic signed [7:0] t;
    t = $signed(x) >>> s;
    return md == 2'd0 ? x << s : md == 2'd1 ? x >> s : md == 2'd2 ? t : (x << s) | (x >> (4'd8 - s));
  endfunction
  always_comb begin
    sv[0] = b.in_valid;
    sd[0] = b.in_data;
    sa[0] = b.in_amt;
    sm[0] = b.in_mode;
    for (int k = 1; k < 3; k++) begin
      sv[k] = v[k-1];
      sd[k] = d[k-1];
      sa[k] = a[k-1];
      sm[k] = m[k-1];
    end
    rdy[2] = !v[2] | b.out_ready;
    rdy[1] = !v[1] | rdy[2];
    rdy[0] = !v[0] | rdy[1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      for (int k = 0; k < 3; k++) begin
        d[k] <= RST_DATA;
        a[k] <= '0;
        m[k] <= '0;
      end
    end else
      for (int k = 0; k < 3; k++)
        if (rdy[k]) begin
          v[k] <= sv[k];
          d[k] <= sa[k][k] ? sh(sd[k], sm[k], 4'(1 << k)) : sd[k];
          a[k] <= sa[k];
          m[k] <= sm[k];
        end
  assign b.in_ready  = rdy[0];
  assign b.out_valid = v[2];
  assign b.out_data  = d[2];
  assign b.busy      = |v;
endmodule

// File: tb/tb_bshift_pipe8.sv
// tb_bshift_pipe8: directed vectors plus scoreboarded random soak for bshift_pipe8
module tb_bshift_pipe8;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  bshift_pipe8_if b();
  bshift_pipe8 dut (.clk(clk), .rst(rst), .b(b));
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int gcyc_q[$];
  bit acc;
  int n_acc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [7:0] mdl(input logic [7:0] x, input logic [2:0] s, input logic [1:0] md);
    logic [15:0] w;
    case (md)
      2'd0: return x << s;
      2'd1: return x >> s;
      2'd2: begin w = {{8{x[7]}}, x} >> s; return w[7:0]; end
      default: begin w = {x, x} << s; return w[15:8]; end
    endcase
  endfunction
  task automatic step(output bit accepted);
    #1;
    accepted = b.in_valid && b.in_ready;
    if (accepted) exp_q.push_back(mdl(b.in_data, b.in_amt, b.in_mode));
    if (b.out_valid && b.out_ready) begin
      got_q.push_back(b.out_data);
      gcyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else chk("scoreboard", b.out_data, exp_q.pop_front());
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic op(input logic [7:0] dat, input logic [2:0] amt, input logic [1:0] md);
    bit ok;
    int i;
    ok = 0;
    i = 0;
    b.in_valid = 1;
    b.in_data = dat;
    b.in_amt = amt;
    b.in_mode = md;
    while (!ok && i < 50) begin
      step(ok);
      i++;
    end
    if (!ok) chk("op_timeout", 0, 1);
    b.in_valid = 0;
  endtask
  task automatic drain;
    int i;
    bit x;
    i = 0;
    b.out_ready = 1;
    while (exp_q.size() > 0 && i < 200) begin
      step(x);
      i++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    b.in_valid = 0;
    b.in_data = 0;
    b.in_amt = 0;
    b.in_mode = 0;
    b.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_out_data", b.out_data, 8'h00);
    rst = 0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", b.in_ready, 1);
    b.in_valid = 1;
    b.in_data = 8'h03;
    b.in_amt = 3'd2;
    b.in_mode = 2'd0;
    step(acc);
    b.in_valid = 0;
    chk("lsl_accept", acc, 1);
    step(acc);
    chk("lsl_early", b.out_valid, 0);
    step(acc);
    chk("lsl_latency", b.out_valid, 1);
    chk("lsl_data", b.out_data, 8'h0C);
    drain;
    got_q.delete();
    gcyc_q.delete();
    op(8'h90, 3'd3, 2'd2);
    op(8'hFF, 3'd7, 2'd1);
    op(8'h80, 3'd7, 2'd2);
    op(8'h7F, 3'd7, 2'd2);
    drain;
    chk("asr_90_3", got_q[0], 8'hF2);
    chk("lsr_ff_7", got_q[1], 8'h01);
    chk("b2b_cycles", gcyc_q[1] - gcyc_q[0], 1);
    chk("asr_80_7", got_q[2], 8'hFF);
    chk("asr_7f_7", got_q[3], 8'h00);
    got_q.delete();
    op(8'h81, 3'd1, 2'd3);
    op(8'h81, 3'd7, 2'd3);
    for (int md = 0; md < 4; md++) op(8'hA5, 3'd0, 2'(md));
    drain;
    chk("rol_81_1", got_q[0], 8'h03);
    chk("rol_81_7", got_q[1], 8'hC0);
    for (int md = 0; md < 4; md++) chk($sformatf("amt0_mode%0d", md), got_q[2+md], 8'hA5);
    got_q.delete();
    b.out_ready = 0;
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      b.in_valid = 1;
      b.in_data = 8'h01;
      b.in_amt = 3'(n_acc);
      b.in_mode = 2'd0;
      step(acc);
      if (acc) n_acc++;
    end
    chk("bp_accepts", n_acc, 3);
    chk("bp_in_ready", b.in_ready, 0);
    chk("bp_busy", b.busy, 1);
    chk("bp_out_valid", b.out_valid, 1);
    chk("bp_no_out", got_q.size(), 0);
    b.out_ready = 1;
    #1;
    chk("bp_full_pass", b.in_ready, 1);
    for (int c = 0; c < 20 && n_acc < 5; c++) begin
      b.in_amt = 3'(n_acc);
      step(acc);
      if (acc) n_acc++;
    end
    b.in_valid = 0;
    drain;
    chk("bp_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_order%0d", i), got_q[i], 8'h01 << i);
    op(8'h11, 3'd1, 2'd0);
    op(8'h22, 3'd1, 2'd0);
    #3;
    rst = 1;
    #1;
    chk("mid_rst_out_valid", b.out_valid, 0);
    chk("mid_rst_busy", b.busy, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("post_rst_busy", b.busy, 0);
    chk("post_rst_in_ready", b.in_ready, 1);
    b.in_valid = 1;
    b.in_data = 8'h05;
    b.in_amt = 3'd1;
    b.in_mode = 2'd0;
    step(acc);
    b.in_valid = 0;
    step(acc);
    chk("post_rst_early", b.out_valid, 0);
    step(acc);
    chk("post_rst_valid", b.out_valid, 1);
    chk("post_rst_data", b.out_data, 8'h0A);
    drain;
    got_q.delete();
    begin
      int sent;
      int c;
      sent = 0;
      c = 0;
      while (sent < 1000 && c < 30000) begin
        if (!b.in_valid && $urandom_range(3) != 0) begin
          b.in_valid = 1;
          b.in_data = 8'($urandom);
          b.in_amt = 3'($urandom);
          b.in_mode = 2'($urandom);
        end
        b.out_ready = $urandom_range(3) != 0;
        step(acc);
        if (acc) begin
          sent++;
          b.in_valid = 0;
        end
        c++;
      end
      b.in_valid = 0;
      chk("soak_sent", sent, 1000);
      drain;
      chk("soak_count", got_q.size(), 1000);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
